// File: rtl/vga_hex_printer.sv
// vga_hex_printer
// Renders a 32-bit value as lowercase hex text into the VGA character
// buffer. Two requesters share the block through round-robin arbitration.
// An accepted request is walked MSB-first, one character per cycle, on the
// text-buffer write port. The port honours wr_ready backpressure.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   reqN_valid/value/addr    request from requester N (N = 0, 1)
//   reqN_ready               request N accepted this cycle (IDLE only)
//   wr_en/wr_addr/wr_data    character write toward the text buffer
//   wr_ready                 text buffer accepts the write this cycle
//   busy                     block is not idle
//   done/done_id             one-cycle completion pulse and requester index
module vga_hex_printer #(
  parameter int ADDR_W     = 12,
  parameter int NUM_DIGITS = 8,
  parameter int PREFIX     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [31:0]       req0_value,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [31:0]       req1_value,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              done_id
);

  localparam int HAS_PREFIX = (PREFIX != 0) ? 1 : 0;
  localparam int L          = NUM_DIGITS + 2 * HAS_PREFIX;
  localparam int IDX_W      = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_value;
  logic [ADDR_W-1:0]  r_base;
  logic               r_id;
  logic               r_lastGrant;

  logic               w_idle;
  logic               w_grant1;
  logic               w_handshake;
  logic               w_lastChar;
  logic [2:0]         w_nibSel;
  logic [3:0]         w_nibble;
  logic [7:0]         w_ascii;

  // Round-robin arbitration. Requester 1 wins when it is the only one asking.
  // On a tie, it wins only if requester 0 got the previous grant. Ready is
  // offered only in IDLE and is suppressed while reset is held.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_grant1    = req1_valid & (~req0_valid | ~r_lastGrant);
    req0_ready  = w_idle & ~rst & req0_valid & ~w_grant1;
    req1_ready  = w_idle & ~rst & w_grant1;
    w_handshake = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    w_lastChar  = (r_idx == LAST_IDX);
  end

  // Next-state logic. EMIT leaves only when the final character is accepted.
  // DONE always lasts exactly one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_handshake) w_nextState = S_EMIT;
      S_EMIT: if (wr_ready && w_lastChar) w_nextState = S_DONE;
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register and request datapath. The value, base address and
  // requester id are captured only at the handshake. A requester may
  // withdraw or change its inputs freely after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_value     <= '0;
      r_base      <= '0;
      r_id        <= 1'b0;
      r_lastGrant <= 1'b1;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_value     <= w_grant1 ? req1_value : req0_value;
            r_base      <= w_grant1 ? req1_addr  : req0_addr;
            r_id        <= w_grant1;
            r_lastGrant <= w_grant1;
            r_idx       <= '0;
          end
        end
        S_EMIT: begin
          if (wr_ready) begin
            r_idx <= w_lastChar ? '0 : r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Character index L-1 is the least significant nibble. Counting down
  // from the last index therefore selects nibbles MSB-first. The prefix
  // characters never reach this path because they are muxed off below.
  always_comb begin
    w_nibSel = 3'(LAST_IDX - r_idx);
    w_nibble = r_value[{w_nibSel, 2'b00} +: 4];
    w_ascii  = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                  : (8'h57 + {4'h0, w_nibble});
  end

  // Moore outputs decoded from registered state only. wr_ready never
  // reaches them combinationally. The write port reads zero outside EMIT.
  always_comb begin
    wr_en   = (r_state == S_EMIT);
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    done_id = (r_state == S_DONE) & r_id;
    wr_addr = '0;
    wr_data = '0;
    if (r_state == S_EMIT) begin
      wr_addr = r_base + ADDR_W'(r_idx);
      if (HAS_PREFIX != 0 && r_idx == '0) begin
        wr_data = 8'h30;
      end else if (HAS_PREFIX != 0 && r_idx == 4'd1) begin
        wr_data = 8'h78;
      end else begin
        wr_data = w_ascii;
      end
    end
  end

endmodule

// File: tb/tb_vga_hex_printer.sv
// tb_vga_hex_printer
// Randomised self-checking bench for vga_hex_printer. The main instance
// uses the default 8-digit configuration. A second instance uses "0x" plus
// 4 digits and exercises prefix output and address wrap. Expected characters
// come from a plain arithmetic hex model, and expected grants come from a
// round-robin model.
module tb_vga_hex_printer;

  logic        clk;
  logic        rst;

  logic        req0_valid, req1_valid;
  logic [31:0] req0_value, req1_value;
  logic [11:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        wr_en, wr_ready, busy, done, done_id;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  logic        pReq0Valid, pReq1Valid;
  logic [31:0] pReq0Value, pReq1Value;
  logic [11:0] pReq0Addr, pReq1Addr;
  logic        pReq0Ready, pReq1Ready;
  logic        pWrEn, pWrReady, pBusy, pDone, pDoneId;
  logic [11:0] pWrAddr;
  logic [7:0]  pWrData;

  int errors = 0;
  int checks = 0;
  int modelLast = 1;

  logic [7:0]  gotData[$];
  logic [11:0] gotAddr[$];
  int emitCycles, lowCount;
  bit doneSeen, doneIdSeen, holdOk, busyOk, readyLeak, timedOut, firstWrEn;

  vga_hex_printer #(.ADDR_W(12), .NUM_DIGITS(8), .PREFIX(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_value(req0_value), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_value(req1_value), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .done_id(done_id)
  );

  vga_hex_printer #(.ADDR_W(12), .NUM_DIGITS(4), .PREFIX(1)) dutP (
    .clk(clk), .rst(rst),
    .req0_valid(pReq0Valid), .req0_value(pReq0Value), .req0_addr(pReq0Addr), .req0_ready(pReq0Ready),
    .req1_valid(pReq1Valid), .req1_value(pReq1Value), .req1_addr(pReq1Addr), .req1_ready(pReq1Ready),
    .wr_en(pWrEn), .wr_addr(pWrAddr), .wr_data(pWrData), .wr_ready(pWrReady),
    .busy(pBusy), .done(pDone), .done_id(pDoneId)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: character k of a request, built from the hex text rules.
  function automatic logic [7:0] modelChar(input logic [31:0] v, input int k,
                                           input int nd, input int pre);
    int d;
    int nib;
    if (pre != 0 && k == 0) return 8'h30;
    if (pre != 0 && k == 1) return 8'h78;
    d   = k - 2 * pre;
    nib = int'((v >> (4 * (nd - 1 - d))) & 32'hF);
    if (nib < 10) return 8'(48 + nib);
    return 8'(97 + nib - 10);
  endfunction

  function automatic logic [11:0] modelAddr(input logic [11:0] base, input int k);
    return 12'((int'(base) + k) % 4096);
  endfunction

  // Expected winner of the round-robin arbiter.
  function automatic int modelGrant(input bit v0, input bit v1);
    if (v0 && v1) return (modelLast == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Holds reset for two cycles with all requests idle.
  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    pReq0Valid = 1'b0; pReq1Valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelLast = 1;
  endtask

  // Presents valids at a falling edge and waits for a ready.
  // who = -1 means no grant was seen within the bound.
  task automatic applyStimulus(input bit v0, input bit v1, output int who, output int waits);
    who = -1;
    waits = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req0_valid = v0;
        req1_valid = v1;
      end
      #1;
      waits = c + 1;
      if (req0_ready && req1_ready) begin who = 2; break; end
      if (req0_ready) begin who = 0; break; end
      if (req1_ready) begin who = 1; break; end
    end
  endtask

  // Follows one transfer of the main instance from the cycle after the
  // handshake up to the done pulse. It records writes and timing flags.
  // dropId: -1 keep valids, 0/1 drop that valid, 2 drop both.
  task automatic checkOutput(input int dropId, input int bpMode);
    logic [11:0] prevAddr;
    logic [7:0]  prevData;
    bit prevStall;
    gotData.delete();
    gotAddr.delete();
    emitCycles = 0; lowCount = 0; doneSeen = 0; doneIdSeen = 0;
    holdOk = 1; busyOk = 1; readyLeak = 0; timedOut = 1; firstWrEn = 0;
    prevStall = 0; prevAddr = '0; prevData = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        if (dropId == 0 || dropId == 2) req0_valid = 1'b0;
        if (dropId == 1 || dropId == 2) req1_valid = 1'b0;
      end
      case (bpMode)
        0: wr_ready = 1'b1;
        1: wr_ready = !((cyc % 4) == 1 || (cyc % 4) == 2);
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 0) firstWrEn = wr_en;
      if (!busy) busyOk = 0;
      if (req0_ready || req1_ready) readyLeak = 1;
      if (done) begin
        doneSeen = 1;
        doneIdSeen = done_id;
        if (wr_en) holdOk = 0;
        timedOut = 0;
        break;
      end
      if (wr_en) begin
        emitCycles++;
        if (prevStall && (wr_addr !== prevAddr || wr_data !== prevData)) holdOk = 0;
        if (wr_ready) begin
          gotAddr.push_back(wr_addr);
          gotData.push_back(wr_data);
          prevStall = 0;
        end else begin
          lowCount++;
          prevStall = 1;
          prevAddr = wr_addr;
          prevData = wr_data;
        end
      end
    end
    wr_ready = 1'b1;
  endtask

  // Reset values, and ready forced low while reset is held.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || done_id !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got wr_en=%b busy=%b done=%b done_id=%b expected 0000",
               wr_en, busy, done, done_id);
    end
    checks++;
    if (wr_addr !== 12'h000 || wr_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_port: got addr=%h data=%h expected 000/00", wr_addr, wr_data);
    end
    checks++;
    if (pWrEn !== 1'b0 || pBusy !== 1'b0 || pDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_prefix_inst: got wr_en=%b busy=%b done=%b expected 000", pWrEn, pBusy, pDone);
    end
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    modelLast = 1;
  endtask

  // Single request on requester 0: the fixed example value and timing.
  task automatic test_single();
    int who, waits;
    logic [31:0] v;
    logic [11:0] a;
    v = 32'h1234ABCD; a = 12'h010;
    req0_value = v; req0_addr = a;
    applyStimulus(1'b1, 1'b0, who, waits);
    checks++;
    if (who !== 0) begin errors++; $display("[TB] FAIL single_grant: got %0d expected 0", who); end
    modelLast = 0;
    checkOutput(0, 0);
    checks++;
    if (firstWrEn !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: got wr_en=%b expected 1", firstWrEn); end
    checks++;
    if (gotData.size() != 8 || emitCycles != 8) begin
      errors++;
      $display("[TB] FAIL single_len: got chars=%0d cycles=%0d expected 8/8", gotData.size(), emitCycles);
    end
    for (int k = 0; k < gotData.size() && k < 8; k++) begin
      checks++;
      if (gotData[k] !== modelChar(v, k, 8, 0) || gotAddr[k] !== modelAddr(a, k)) begin
        errors++;
        $display("[TB] FAIL single_char%0d: got (%h,%h) expected (%h,%h)", k,
                 gotAddr[k], gotData[k], modelAddr(a, k), modelChar(v, k, 8, 0));
      end
    end
    checks++;
    if (!doneSeen || doneIdSeen !== 1'b0 || !busyOk || !holdOk) begin
      errors++;
      $display("[TB] FAIL single_done: got done=%b id=%b busy_ok=%b expected 1/0/1", doneSeen, doneIdSeen, busyOk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got busy=%b done=%b expected 00", busy, done);
    end
  endtask

  // Both requesters held valid from reset: grants alternate 0,1,0,1 and
  // each next grant comes in the first IDLE cycle after done.
  task automatic test_tie();
    int who, waits, expWho;
    logic [31:0] v;
    logic [11:0] a;
    applyReset();
    req0_value = 32'hDEADBEEF; req0_addr = 12'h100;
    req1_value = 32'h00000000; req1_addr = 12'h200;
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b1, 1'b1, who, waits);
      expWho = modelGrant(1'b1, 1'b1);
      modelLast = expWho;
      checks++;
      if (who !== expWho) begin errors++; $display("[TB] FAIL tie_grant%0d: got %0d expected %0d", t, who, expWho); end
      if (t > 0) begin
        checks++;
        if (waits != 1) begin errors++; $display("[TB] FAIL tie_gap%0d: got %0d cycles expected 1", t, waits); end
      end
      v = (expWho == 0) ? 32'hDEADBEEF : 32'h00000000;
      a = (expWho == 0) ? 12'h100 : 12'h200;
      checkOutput((t == 3) ? 2 : -1, 0);
      checks++;
      if (gotData.size() != 8 || !doneSeen || doneIdSeen !== 1'(expWho) || readyLeak) begin
        errors++;
        $display("[TB] FAIL tie_xfer%0d: got chars=%0d done=%b id=%b leak=%b expected 8/1/%0d/0",
                 t, gotData.size(), doneSeen, doneIdSeen, readyLeak, expWho);
      end
      for (int k = 0; k < gotData.size() && k < 8; k++) begin
        checks++;
        if (gotData[k] !== modelChar(v, k, 8, 0) || gotAddr[k] !== modelAddr(a, k)) begin
          errors++;
          $display("[TB] FAIL tie_char%0d_%0d: got (%h,%h) expected (%h,%h)", t, k,
                   gotAddr[k], gotData[k], modelAddr(a, k), modelChar(v, k, 8, 0));
        end
      end
    end
  endtask

  // Patterned and random wr_ready: hold, no loss or duplication, and cycle count.
  task automatic test_backpressure();
    int who, waits;
    logic [31:0] v;
    logic [11:0] a;
    for (int r = 0; r < 3; r++) begin
      v = $urandom;
      a = 12'($urandom);
      req1_value = v; req1_addr = a;
      applyStimulus(1'b0, 1'b1, who, waits);
      modelLast = 1;
      checks++;
      if (who !== 1) begin errors++; $display("[TB] FAIL bp_grant%0d: got %0d expected 1", r, who); end
      checkOutput(1, (r == 0) ? 1 : 2);
      checks++;
      if (timedOut || emitCycles != 8 + lowCount || !holdOk || doneIdSeen !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_timing%0d: got cycles=%0d hold=%b id=%b expected %0d/1/1",
                 r, emitCycles, holdOk, doneIdSeen, 8 + lowCount);
      end
      checks++;
      if (gotData.size() != 8) begin errors++; $display("[TB] FAIL bp_count%0d: got %0d expected 8", r, gotData.size()); end
      for (int k = 0; k < gotData.size() && k < 8; k++) begin
        checks++;
        if (gotData[k] !== modelChar(v, k, 8, 0) || gotAddr[k] !== modelAddr(a, k)) begin
          errors++;
          $display("[TB] FAIL bp_char%0d_%0d: got (%h,%h) expected (%h,%h)", r, k,
                   gotAddr[k], gotData[k], modelAddr(a, k), modelChar(v, k, 8, 0));
        end
      end
    end
  endtask

  // Random requester mix with random values, addresses and backpressure.
  task automatic test_random();
    int who, waits, expWho, sel;
    logic [31:0] v0, v1, v;
    logic [11:0] a0, a1, a;
    for (int r = 0; r < 8; r++) begin
      sel = int'($urandom_range(1, 3));
      v0 = $urandom; v1 = $urandom;
      a0 = 12'($urandom); a1 = 12'($urandom);
      req0_value = v0; req0_addr = a0;
      req1_value = v1; req1_addr = a1;
      expWho = modelGrant(sel[0], sel[1]);
      applyStimulus(sel[0], sel[1], who, waits);
      modelLast = expWho;
      checks++;
      if (who !== expWho) begin errors++; $display("[TB] FAIL rand_grant%0d: got %0d expected %0d", r, who, expWho); end
      v = (expWho == 0) ? v0 : v1;
      a = (expWho == 0) ? a0 : a1;
      checkOutput(2, 2);
      checks++;
      if (timedOut || gotData.size() != 8 || emitCycles != 8 + lowCount || doneIdSeen !== 1'(expWho)) begin
        errors++;
        $display("[TB] FAIL rand_xfer%0d: got chars=%0d cycles=%0d id=%b expected 8/%0d/%0d",
                 r, gotData.size(), emitCycles, doneIdSeen, 8 + lowCount, expWho);
      end
      for (int k = 0; k < gotData.size() && k < 8; k++) begin
        checks++;
        if (gotData[k] !== modelChar(v, k, 8, 0) || gotAddr[k] !== modelAddr(a, k)) begin
          errors++;
          $display("[TB] FAIL rand_char%0d_%0d: got (%h,%h) expected (%h,%h)", r, k,
                   gotAddr[k], gotData[k], modelAddr(a, k), modelChar(v, k, 8, 0));
        end
      end
    end
  endtask

  // Prefix instance: "0x" plus 4 digits, including address wrap past 0xFFF.
  task automatic test_prefix();
    logic [7:0]  lit[6];
    logic [7:0]  pData[$];
    logic [11:0] pAddr[$];
    logic [31:0] v;
    logic [11:0] a;
    bit granted, pDoneSeen, pIdSeen;
    lit[0] = 8'h30; lit[1] = 8'h78; lit[2] = 8'h66; lit[3] = 8'h30; lit[4] = 8'h30; lit[5] = 8'h61;
    for (int r = 0; r < 2; r++) begin
      v = (r == 0) ? 32'h0000F00A : $urandom;
      a = (r == 0) ? 12'hFFE : 12'($urandom);
      pData.delete(); pAddr.delete();
      granted = 0; pDoneSeen = 0; pIdSeen = 0;
      pWrReady = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (c == 0) begin
          if (r == 0) begin pReq0Value = v; pReq0Addr = a; pReq0Valid = 1'b1; end
          else begin pReq1Value = v; pReq1Addr = a; pReq1Valid = 1'b1; end
        end
        #1;
        if ((r == 0 && pReq0Ready) || (r == 1 && pReq1Ready)) begin granted = 1; break; end
      end
      checks++;
      if (!granted) begin errors++; $display("[TB] FAIL prefix_grant%0d: got no ready expected ready", r); end
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (c == 0) begin pReq0Valid = 1'b0; pReq1Valid = 1'b0; end
        #1;
        if (pDone) begin pDoneSeen = 1; pIdSeen = pDoneId; break; end
        if (pWrEn && pWrReady) begin pData.push_back(pWrData); pAddr.push_back(pWrAddr); end
      end
      checks++;
      if (pData.size() != 6 || !pDoneSeen || pIdSeen !== 1'(r)) begin
        errors++;
        $display("[TB] FAIL prefix_xfer%0d: got chars=%0d done=%b id=%b expected 6/1/%0d",
                 r, pData.size(), pDoneSeen, pIdSeen, r);
      end
      for (int k = 0; k < pData.size() && k < 6; k++) begin
        checks++;
        if (pData[k] !== modelChar(v, k, 4, 1) || pAddr[k] !== modelAddr(a, k)) begin
          errors++;
          $display("[TB] FAIL prefix_char%0d_%0d: got (%h,%h) expected (%h,%h)", r, k,
                   pAddr[k], pData[k], modelAddr(a, k), modelChar(v, k, 4, 1));
        end
        if (r == 0) begin
          checks++;
          if (pData[k] !== lit[k]) begin
            errors++;
            $display("[TB] FAIL prefix_literal%0d: got %h expected %h", k, pData[k], lit[k]);
          end
        end
      end
    end
  endtask

  // Reset after 3 accepted characters aborts at once. After that, a tie
  // favours requester 0 again.
  task automatic test_mid_reset();
    int who, waits;
    logic [31:0] v, v1;
    logic [11:0] a;
    bit quiet;
    v = $urandom; a = 12'($urandom);
    req0_value = v; req0_addr = a;
    applyStimulus(1'b1, 1'b0, who, waits);
    checks++;
    if (who !== 0) begin errors++; $display("[TB] FAIL midrst_grant: got %0d expected 0", who); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      wr_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b1 || wr_data !== modelChar(v, 3, 8, 0) || wr_addr !== modelAddr(a, 3)) begin
      errors++;
      $display("[TB] FAIL midrst_fourth: got (%b,%h,%h) expected (1,%h,%h)", wr_en, wr_addr, wr_data,
               modelAddr(a, 3), modelChar(v, 3, 8, 0));
    end
    @(negedge clk);
    rst = 1'b0;
    modelLast = 1;
    #1;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_addr !== 12'h000 || wr_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst_abort: got wr_en=%b busy=%b done=%b addr=%h data=%h expected 0/0/0/000/00",
               wr_en, busy, done, wr_addr, wr_data);
    end
    quiet = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (wr_en || done || busy) quiet = 0;
    end
    checks++;
    if (!quiet) begin errors++; $display("[TB] FAIL midrst_quiet: got activity expected none"); end
    v1 = $urandom;
    v = $urandom;
    req0_value = v; req1_value = v1;
    applyStimulus(1'b1, 1'b1, who, waits);
    checks++;
    if (who !== modelGrant(1'b1, 1'b1)) begin
      errors++;
      $display("[TB] FAIL midrst_tie: got %0d expected %0d", who, modelGrant(1'b1, 1'b1));
    end
    modelLast = 0;
    checkOutput(2, 0);
    checks++;
    if (gotData.size() != 8 || gotData[0] !== modelChar(v, 0, 8, 0) || doneIdSeen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_after: got chars=%0d first=%h id=%b expected 8/%h/0",
               gotData.size(), (gotData.size() > 0) ? gotData[0] : 8'h00, doneIdSeen, modelChar(v, 0, 8, 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_value = '0; req1_value = '0; req0_addr = '0; req1_addr = '0;
    wr_ready = 1'b1;
    pReq0Valid = 1'b0; pReq1Valid = 1'b0;
    pReq0Value = '0; pReq1Value = '0; pReq0Addr = '0; pReq1Addr = '0;
    pWrReady = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_random();
    test_prefix();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
